// File: rtl/sha256_wb_block_loader_if.sv
// ============================================================================
// Module      : sha256_wb_block_loader_if
// Description : Wishbone B3 classic bus bundle for the SHA-256 block loader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sha256_wb_block_loader_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

`default_nettype wire

// File: rtl/sha256_wb_block_loader.sv
// ============================================================================
// Module      : sha256_wb_block_loader
// Description : Wishbone slave that assembles 512-bit blocks for a SHA-256
//               core, issues init/next and latches the digest for readback.
//               Optional macro SHA256_WB_LOADER_AUTOSTART_EN starts a hash as
//               soon as the last missing block word is written.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sha256_wb_block_loader #(
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  wire logic                  clk,
  input  wire logic                  rst_sys_n,
  sha256_wb_block_loader_if.slave    wb,
  output logic                       core_init_o,
  output logic                       core_next_o,
  output logic [511:0]               core_block_o,
  input  wire logic                  core_ready_i,
  input  wire logic [255:0]          core_digest_i,
  input  wire logic                  core_digest_valid_i,
  output logic                       done_o
);

  localparam logic [5:0]  ADR_CTRL   = 6'h00;
  localparam logic [5:0]  ADR_STATUS = 6'h01;
  localparam logic [15:0] FULL_MASK  = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] blk_buf [16];
  logic [31:0] digest_w [8];
  logic [15:0] wmask;
  logic        dvalid;
  logic        timeout_flag;
  logic        chain_ok;
  logic [31:0] wait_cnt;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  logic        req;
  logic [5:0]  word;
  logic [3:0]  blk_idx;
  logic [2:0]  dig_idx;
  logic        is_blk;
  logic        is_dig;
  logic        idle;
  logic        timeout_hit;
  logic [15:0] mask_next;
  logic [31:0] merged;
  logic [31:0] status_word;
  logic        rsp_ack;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic        blk_wr;
  logic        go_init;
  logic        go_next;
  logic        unused_adr;

  assign wb.wb_ack_o = bus_ack;
  assign wb.wb_err_o = bus_err;
  assign wb.wb_dat_o = bus_rdata;

  // A request already terminated must not be taken again while ack/err is high.
  assign req         = wb.wb_cyc_i & wb.wb_stb_i & ~bus_ack & ~bus_err;
  assign word        = wb.wb_adr_i[7:2];
  assign blk_idx     = word[3:0];
  assign dig_idx     = word[2:0];
  assign is_blk      = (word[5:4] == 2'b01);
  assign is_dig      = (word[5:3] == 3'b100);
  assign idle        = (state == ST_IDLE);
  assign mask_next   = wmask | (16'd1 << blk_idx);
  assign status_word = {wmask, 12'd0, chain_ok, timeout_flag, dvalid, ~idle};
  assign unused_adr  = ^{wb.wb_adr_i[31:8], wb.wb_adr_i[1:0]};

  generate
    for (genvar i = 0; i < 16; i++) begin : g_pack
      assign core_block_o[511 - 32*i -: 32] = blk_buf[i];
    end
  endgenerate

  generate
    if (WAIT_TIMEOUT != 0) begin : g_timeout
      localparam logic [31:0] TIMEOUT_LAST = 32'(WAIT_TIMEOUT - 1);
      assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    merged = blk_buf[blk_idx];
    for (int b = 0; b < 4; b++) begin
      if (wb.wb_sel_i[b]) begin
        merged[8*b +: 8] = wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    rsp_ack  = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = 32'd0;
    blk_wr   = 1'b0;
    go_init  = 1'b0;
    go_next  = 1'b0;
    if (req) begin
      if (!wb.wb_we_i) begin
        if (word == ADR_CTRL) begin
          rsp_ack = 1'b1;
        end else if (word == ADR_STATUS) begin
          rsp_ack  = 1'b1;
          rsp_data = status_word;
        end else if (is_blk) begin
          rsp_ack  = 1'b1;
          rsp_data = blk_buf[blk_idx];
        end else if (is_dig) begin
          rsp_ack  = 1'b1;
          rsp_data = digest_w[dig_idx];
        end else begin
          rsp_err = 1'b1;
        end
      end else if (is_blk) begin
        if (idle) begin
          rsp_ack = 1'b1;
          blk_wr  = 1'b1;
        end else begin
          rsp_err = 1'b1;
        end
      end else if (word == ADR_CTRL) begin
        if (!idle) begin
          rsp_err = 1'b1;
        end else if (wb.wb_dat_i[0]) begin
          if ((wmask == FULL_MASK) && core_ready_i) begin
            rsp_ack = 1'b1;
            go_init = 1'b1;
          end else begin
            rsp_err = 1'b1;
          end
        end else if (wb.wb_dat_i[1]) begin
          if ((wmask == FULL_MASK) && core_ready_i && chain_ok) begin
            rsp_ack = 1'b1;
            go_next = 1'b1;
          end else begin
            rsp_err = 1'b1;
          end
        end else begin
          rsp_ack = 1'b1;
        end
      end else begin
        rsp_err = 1'b1;
      end
    end
`ifdef SHA256_WB_LOADER_AUTOSTART_EN
    // Only the write that completes the mask triggers; rewrites of a full block do not.
    if (blk_wr && (mask_next == FULL_MASK) && (wmask != FULL_MASK) && core_ready_i) begin
      go_init = ~chain_ok;
      go_next = chain_ok;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state        <= ST_IDLE;
      wmask        <= 16'd0;
      dvalid       <= 1'b0;
      timeout_flag <= 1'b0;
      chain_ok     <= 1'b0;
      wait_cnt     <= 32'd0;
      bus_ack      <= 1'b0;
      bus_err      <= 1'b0;
      bus_rdata    <= 32'd0;
      core_init_o  <= 1'b0;
      core_next_o  <= 1'b0;
      done_o       <= 1'b0;
      for (int i = 0; i < 16; i++) blk_buf[i] <= 32'd0;
      for (int i = 0; i < 8; i++) digest_w[i] <= 32'd0;
    end else begin
      bus_ack     <= rsp_ack;
      bus_err     <= rsp_err;
      bus_rdata   <= rsp_data;
      core_init_o <= 1'b0;
      core_next_o <= 1'b0;
      done_o      <= 1'b0;

      if (blk_wr) begin
        blk_buf[blk_idx] <= merged;
        wmask            <= mask_next;
      end

      case (state)
        ST_IDLE: begin
          if (go_init || go_next) begin
            core_init_o  <= go_init;
            core_next_o  <= go_next;
            dvalid       <= 1'b0;
            timeout_flag <= 1'b0;
            wait_cnt     <= 32'd0;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (timeout_hit) begin
            timeout_flag <= 1'b1;
            chain_ok     <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
            if (!core_ready_i) state <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (timeout_hit) begin
            timeout_flag <= 1'b1;
            chain_ok     <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
            if (core_ready_i && core_digest_valid_i) state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          for (int i = 0; i < 8; i++) digest_w[i] <= core_digest_i[255 - 32*i -: 32];
          dvalid   <= 1'b1;
          chain_ok <= 1'b1;
          wmask    <= 16'd0;
          done_o   <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
